// File: rtl/sorting_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_pkg
//  Description : Shared types and helpers for the packet sorting unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package sorting_pkg;

    // Controller states, encoded in two bits.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        SORT    = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Maximum packet length (MAX_LEN) for a given address width.
    function automatic int max_len(input int awidth);
        return 1 << awidth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sorting_cas.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_cas
//  Description : Unsigned compare-and-swap cell. When enabled, the smaller of
//                the two words leaves on lo_o and the larger on hi_o; when
//                disabled both words pass straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
module sorting_cas #(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    input  logic              en_i,
    output logic [DWIDTH-1:0] lo_o,
    output logic [DWIDTH-1:0] hi_o
);

    logic swap;

    assign swap = en_i && (a_i > b_i);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule
`default_nettype wire

// File: rtl/sorting_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_unit
//  Description : Captures one framed packet of up to 2**AWIDTH words, sorts it
//                ascending with an odd-even transposition network over
//                2**AWIDTH cycles, then replays it as a framed stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module sorting_unit
    import sorting_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              busy_o
);

    localparam int              MAX_LEN  = max_len(AWIDTH);
    localparam logic [AWIDTH:0] LAST_IDX = (AWIDTH+1)'(MAX_LEN - 1);
    localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);

    state_t            state_q;
    logic [AWIDTH:0]   cnt_q;
    // Sort round number in SORT; index of the next word to emit in OUTPUT.
    logic [AWIDTH:0]   step_q;
    logic [DWIDTH-1:0] mem_q    [MAX_LEN];
    logic [DWIDTH-1:0] sorted_d [MAX_LEN];
    logic [DWIDTH-1:0] data_q;
    logic              sop_q;
    logic              eop_q;
    logic              val_q;
    logic              busy_q;

    logic [MAX_LEN-2:0] cas_en;
    logic [DWIDTH-1:0]  cas_lo [MAX_LEN-1];
    logic [DWIDTH-1:0]  cas_hi [MAX_LEN-1];

    // One cell per adjacent pair; even rounds use even-based pairs, odd rounds
    // odd-based pairs, and pairs reaching past the packet end stay untouched.
    generate
        for (genvar k = 0; k < MAX_LEN - 1; k++) begin : g_cas
            localparam logic            PAIR_PARITY = 1'(k % 2);
            localparam logic [AWIDTH:0] HI_IDX      = (AWIDTH+1)'(k + 1);

            assign cas_en[k] = (step_q[0] == PAIR_PARITY) && (HI_IDX < cnt_q);

            sorting_cas #(
                .DWIDTH (DWIDTH)
            ) u_cas (
                .a_i  (mem_q[k]),
                .b_i  (mem_q[k+1]),
                .en_i (cas_en[k]),
                .lo_o (cas_lo[k]),
                .hi_o (cas_hi[k])
            );
        end

        // Pairs active in one round are disjoint, so each entry is fed by at
        // most one cell: as the upper member of pair i-1 or lower of pair i.
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_sel
            if (i == 0) begin : g_first
                assign sorted_d[i] = cas_en[i] ? cas_lo[i] : mem_q[i];
            end else if (i == MAX_LEN - 1) begin : g_last
                assign sorted_d[i] = cas_en[i-1] ? cas_hi[i-1] : mem_q[i];
            end else begin : g_mid
                assign sorted_d[i] = cas_en[i-1] ? cas_hi[i-1] :
                                     cas_en[i]   ? cas_lo[i]   : mem_q[i];
            end
        end
    endgenerate

    // Controller: capture, sort rounds, replay and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (val_i && sop_i) begin
                        mem_q[0] <= data_i;
                        cnt_q    <= CNT_ONE;
                        step_q   <= '0;
                        if (eop_i) begin
                            state_q <= SORT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= RECEIVE;
                        end
                    end
                end

                RECEIVE: begin
                    if (val_i) begin
                        if (sop_i && !eop_i) begin
                            mem_q[0] <= data_i;
                            cnt_q    <= CNT_ONE;
                        end else begin
                            mem_q[cnt_q[AWIDTH-1:0]] <= data_i;
                            cnt_q <= cnt_q + CNT_ONE;
                            // Filling the last slot closes the packet.
                            if (eop_i || (cnt_q == LAST_IDX)) begin
                                state_q <= SORT;
                                busy_q  <= 1'b1;
                                step_q  <= '0;
                            end
                        end
                    end
                end

                SORT: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        mem_q[i] <= sorted_d[i];
                    end
                    step_q <= step_q + CNT_ONE;
                    if (step_q == LAST_IDX) begin
                        // Entry 0 is taken from the final round's result.
                        state_q <= OUTPUT;
                        data_q  <= sorted_d[0];
                        sop_q   <= 1'b1;
                        eop_q   <= (cnt_q == CNT_ONE);
                        val_q   <= 1'b1;
                        step_q  <= CNT_ONE;
                    end
                end

                OUTPUT: begin
                    if (step_q == cnt_q) begin
                        state_q <= IDLE;
                        step_q  <= '0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                        val_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q <= mem_q[step_q[AWIDTH-1:0]];
                        sop_q  <= 1'b0;
                        eop_q  <= (step_q == (cnt_q - CNT_ONE));
                        step_q <= step_q + CNT_ONE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o = data_q;
    assign sop_o  = sop_q;
    assign eop_o  = eop_q;
    assign val_o  = val_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sorting_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sorting_unit
//  Description : Self-checking bench for sorting_unit with a queue-based
//                reference sort and cycle-exact framing/timing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sorting_unit;

    localparam int DWIDTH  = 8;
    localparam int AWIDTH  = 3;
    localparam int MAX_LEN = 1 << AWIDTH;

    typedef logic [DWIDTH-1:0] wq_t[$];

    logic              clk_i = 1'b0;
    logic              srst_i;
    logic [DWIDTH-1:0] data_i;
    logic              sop_i;
    logic              eop_i;
    logic              val_i;
    logic [DWIDTH-1:0] data_o;
    logic              sop_o;
    logic              eop_o;
    logic              val_o;
    logic              busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    sorting_unit #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .data_i (data_i),
        .sop_i  (sop_i),
        .eop_i  (eop_i),
        .val_i  (val_i),
        .data_o (data_o),
        .sop_o  (sop_o),
        .eop_o  (eop_o),
        .val_o  (val_o),
        .busy_o (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: ascending order by insertion into a growing queue.
    function automatic wq_t ref_sort(input wq_t in);
        wq_t out;
        foreach (in[j]) begin
            int pos = 0;
            while (pos < out.size() && out[pos] <= in[j]) pos++;
            out.insert(pos, in[j]);
        end
        return out;
    endfunction

    task automatic idle_inputs();
        data_i = '0;
        sop_i  = 1'b0;
        eop_i  = 1'b0;
        val_i  = 1'b0;
    endtask

    // Present one input cycle, then move to just after the capturing edge.
    task automatic drive(input logic [DWIDTH-1:0] d, input logic s, input logic e, input logic v);
        data_i = d;
        sop_i  = s;
        eop_i  = e;
        val_i  = v;
        @(posedge clk_i);
        #1;
    endtask

    // Gap cycles carry random data and framing with val low.
    task automatic send_packet(input wq_t w, input bit use_eop, input int max_gap);
        for (int i = 0; i < w.size(); i++) begin
            if (i > 0 && max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0))
                    drive(DWIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            drive(w[i], 1'(i == 0), 1'(use_eop && (i == w.size() - 1)), 1'b1);
        end
        idle_inputs();
    endtask

    // Called in cycle T+1; checks SORT, OUTPUT and the cycle after eop.
    task automatic check_output(input wq_t exp);
        int n = exp.size();
        repeat (MAX_LEN) begin
            @(negedge clk_i);
            check("sort_flags", 32'({busy_o, val_o, sop_o, eop_o}), 32'(4'b1000));
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            check("out_flags", 32'({busy_o, val_o, sop_o, eop_o}),
                  32'({1'b1, 1'b1, 1'(i == 0), 1'(i == n - 1)}));
            check("out_data", 32'(data_o), 32'(exp[i]));
        end
        @(negedge clk_i);
        check("after_eop", 32'({busy_o, val_o, sop_o, eop_o}), 32'(0));
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_packet(input wq_t w, input bit use_eop, input int max_gap);
        send_packet(w, use_eop, max_gap);
        check_output(ref_sort(w));
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk_i);
        check(tag, 32'({data_o, sop_o, eop_o, val_o, busy_o}), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        wq_t pkt;
        wq_t exp;

        idle_inputs();
        srst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        check_reset_outputs("reset_state");
        @(posedge clk_i);
        #1;

        // Stray words without sop must be dropped, then a 3-word packet.
        drive(8'd77, 1'b0, 1'b0, 1'b1);
        drive(8'd66, 1'b0, 1'b1, 1'b1);
        idle_inputs();
        pkt = '{8'd200, 8'd5, 8'd17};
        run_packet(pkt, 1'b1, 0);

        pkt = '{8'd9, 8'd255, 8'd0, 8'd9, 8'd3, 8'd128, 8'd0};
        run_packet(pkt, 1'b1, 0);

        pkt = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        run_packet(pkt, 1'b1, 0);
        run_packet(pkt, 1'b0, 0);

        pkt = '{8'd42};
        run_packet(pkt, 1'b1, 0);

        // Traffic during SORT must be ignored.
        pkt = '{8'd10, 8'd3, 8'd250, 8'd1};
        send_packet(pkt, 1'b1, 1);
        fork
            check_output(ref_sort(pkt));
            begin
                drive(8'd1,  1'b1, 1'b0, 1'b1);
                drive(8'd2,  1'b0, 1'b0, 1'b1);
                drive(8'd3,  1'b0, 1'b1, 1'b1);
                drive(8'd99, 1'b1, 1'b1, 1'b1);
                idle_inputs();
            end
        join

        for (int p = 0; p < 100; p++) begin
            int len = $urandom_range(7, 3);
            pkt = {};
            repeat ($urandom_range(2, 0))
                drive(DWIDTH'($urandom), 1'b0, 1'($urandom), 1'b1);
            idle_inputs();
            for (int i = 0; i < len; i++) pkt.push_back(DWIDTH'($urandom));
            run_packet(pkt, 1'b1, 2);
        end

        // Reset in the middle of OUTPUT.
        pkt = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        exp = ref_sort(pkt);
        send_packet(pkt, 1'b1, 0);
        repeat (MAX_LEN + 2) @(negedge clk_i);
        check("pre_reset_out", 32'({val_o, data_o}), 32'({1'b1, exp[1]}));
        @(posedge clk_i);
        #1;
        srst_i = 1'b1;
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        check_reset_outputs("reset_mid_output");
        check_reset_outputs("reset_stays_idle");
        @(posedge clk_i);
        #1;
        pkt = '{8'd33, 8'd11, 8'd22, 8'd11, 8'd0, 8'd255};
        run_packet(pkt, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sorting_unit.md
# sorting_unit

Packet sorter: accepts one packet of up to 2**AWIDTH unsigned words on a sop/eop/valid stream, sorts it ascending, and replays it on an identical output stream. It sits inline on a framed data path. It processes one packet at a time and flags `busy_o` while sorting or replaying.

## Interface
- `DWIDTH`, 8: data word width; words are compared as unsigned values.
- `AWIDTH`, 3: log2 of the maximum packet length (max length 2**AWIDTH = 8).
- `clk_i` in 1: clock; all logic is on the rising edge.
- `srst_i` in 1: reset, synchronous and active-high.
- `data_i` in DWIDTH: input word.
- `sop_i` in 1: first word of the packet, qualified by `val_i`.
- `eop_i` in 1: last word of the packet, qualified by `val_i`.
- `val_i` in 1: input word valid.
- `data_o` out DWIDTH: sorted output word.
- `sop_o` out 1: first output word.
- `eop_o` out 1: last output word.
- `val_o` out 1: output word valid.
- `busy_o` out 1: high while sorting or outputting; input is ignored while high.

## Operation
- Storage is an array of 2**AWIDTH × DWIDTH registers plus a word count `cnt` of width AWIDTH+1.
- The state machine has four states: IDLE, RECEIVE, SORT and OUTPUT.
- **IDLE**: `val_i & sop_i` writes `data_i` to entry 0 and sets `cnt=1`.
  - If `eop_i` is also high, go to SORT (single-word packet).
  - Otherwise go to RECEIVE.
  - Words without sop are dropped.
- **RECEIVE**: each `val_i` cycle writes `data_i` to entry `cnt` and increments `cnt`.
  - Cycles with `val_i` low are gaps and are ignored.
  - `val_i & eop_i` writes the word and goes to SORT.
  - `val_i & sop_i` (without eop) restarts the packet: the word goes to entry 0 and `cnt=1`.
  - If the word written is entry 2**AWIDTH-1, it is treated as eop and the FSM goes to SORT.
- **SORT**: odd-even transposition sort for exactly 2**AWIDTH cycles.
  - Even-numbered cycles compare-exchange pairs (0,1),(2,3),…
  - Odd-numbered cycles compare-exchange pairs (1,2),(3,4),…
  - A pair (k,k+1) is processed only if k+1 < `cnt`.
  - Each exchange leaves the smaller value at the lower index.
  - Then go to OUTPUT.
- **OUTPUT**: emit entries 0..`cnt`-1, one per cycle and contiguously, with `val_o=1`.
  - `sop_o=1` on entry 0 only.
  - `eop_o=1` on entry `cnt`-1 only.
  - When `cnt=1`, sop and eop are asserted together.
  - Then go to IDLE.
- `busy_o=1` exactly in SORT and OUTPUT.
- All input is ignored while `busy_o=1`.
- Output ordering is ascending. Equal values are all emitted, and the relative order of duplicates is irrelevant.
- Reset, from any state including mid-SORT or mid-OUTPUT, returns the FSM to IDLE and sets `cnt=0`.
  - All outputs reset to 0: `data_o`, `sop_o`, `eop_o`, `val_o`, `busy_o`.
  - Array contents are don't-care after reset.

## Timing
- All outputs are registered.
- Let T be the cycle in which eop is accepted.
  - `busy_o` rises at T+1.
  - SORT occupies T+1..T+2**AWIDTH.
  - The first output word (`val_o`, `sop_o`) is at T+2**AWIDTH+1.
  - The last word (`eop_o`) is at T+2**AWIDTH+`cnt`.
- `busy_o` is high through the `eop_o` cycle and is low in the following cycle. `val_o` is also low then.
- `val_o`, `sop_o` and `eop_o` are 0 whenever the FSM is not in OUTPUT. `data_o` is don't-care when `val_o=0`.
- The next packet's sop may be presented in the cycle after `busy_o` falls.

## Structure
- Package `sorting_pkg` holds the state enum (IDLE, RECEIVE, SORT, OUTPUT) and the helper constant MAX_LEN = 2**AWIDTH, expressed as a function of the parameter.
- One sub-module, `sorting_cas`: a parameterized DWIDTH compare-and-swap cell (inputs a, b, enable; outputs lo, hi), instantiated for each adjacent pair.
- Top level holds the FSM, the counters, the register array and the output registers.

## Test plan
- **Reset**: hold `srst_i` for 1 cycle → all outputs 0 and `busy_o=0` at the next edge.
- **3-word packet**: send 200, 5, 17 (sop on 200, eop on 17) → `busy_o` high at T+1; output 5 (sop), 17, 200 (eop) on 3 contiguous cycles starting T+9; `busy_o` low the cycle after 200.
- **7-word packet with duplicates**: send 9, 255, 0, 9, 3, 128, 0 → output 0, 0, 3, 9, 9, 128, 255; sop on the first word only, eop on the last only.
- **Full and single-word packets**:
  - 8 words 7, 6, 5, 4, 3, 2, 1, 0 (eop on the 8th) → output 0..7 ascending.
  - 8 words with no eop → treated as eop, same output.
  - Single word 42 with sop and eop together → one output cycle with `sop_o = eop_o = 1`.
- **Input while busy**: drive sop, words and eop during SORT → ignored; output equals the original packet sorted.
- **Regression and mid-operation reset**:
  - 100 random packets of length 3..7, each sent after `busy_o` falls → each output matches the sorted input.
  - Assert reset mid-OUTPUT → outputs 0 next cycle; a subsequent packet sorts correctly.
